bcd_ascii_sender: RTL and testbench

BCD_ASCII_SENDER -- requirements
Module: bcd_ascii_sender

---
 rtl/bcd_ascii_sender.sv | 254 +++++++++++++++++++++++++
 tb/tb_bcd_ascii_sender.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_ascii_sender.sv
// ---------------------------------------------------------------------------
// bcd_ascii_sender
//
// Purpose:
//   Streams a packed BCD value to a UART transmitter as an ASCII text line.
//   Each frame is: the digits (most significant first), an optional decimal
//   point, then CR and LF. Uses a valid/ready handshake toward the
//   transmitter.
//
// Optional feature (compile-time macro):
//   LEADING_ZERO_BLANK_EN - when defined, leading '0' digits are skipped
//   up to the first nonzero digit or the integer-units digit, whichever
//   comes first. Skipped digits take no cycle and emit no byte. When
//   undefined, all NDIG digits are always sent.
//
// Parameters:
//   NDIG      number of BCD digits per frame (2..8)
//
// Ports:
//   clk       in   1        sole clock, rising edge
//   rst       in   1        synchronous active-high reset
//   start     in   1        frame request, only looked at while idle
//   bcd       in   4*NDIG   packed BCD value, MS digit in the top nibble
//   dp_pos    in   4        number of fractional digits (0 or >=NDIG: none)
//   tx_data   out  8        ASCII byte for the transmitter
//   tx_valid  out  1        tx_data is valid
//   tx_ready  in   1        transmitter accepts the byte this edge
//   busy      out  1        high from frame acceptance to frame end
//   done      out  1        one-cycle pulse after the LF byte is taken
// ---------------------------------------------------------------------------
module bcd_ascii_sender #(
  parameter int NDIG = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd,
  input  logic [3:0]        dp_pos,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  // State names the byte currently being presented on tx_data.
  typedef enum logic [2:0] {
    IDLE,
    DIGIT,
    POINT,
    CR,
    LF
  } state_t;

  localparam logic [3:0] LAST_IDX    = 4'(NDIG - 1);
  localparam logic [3:0] NDIG_W      = 4'(NDIG);
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_QUERY = 8'h3F;
  localparam logic [7:0] ASCII_POINT = 8'h2E;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  // Nibble to ASCII; anything that is not a decimal digit becomes '?'.
  function automatic logic [7:0] to_ascii(input logic [3:0] nib);
    logic [7:0] res;
    if (nib <= 4'd9) begin
      res = ASCII_ZERO | {4'h0, nib};
    end else begin
      res = ASCII_QUERY;
    end
    return res;
  endfunction

  // Digit at index idx, counted from the MS digit (idx 0). Out-of-range
  // indices return 0; callers only use them where the result is discarded.
  function automatic logic [3:0] digit_at(input logic [4*NDIG-1:0] vec,
                                          input logic [3:0]        idx);
    logic [3:0] nib;
    nib = 4'h0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx == 4'(i)) begin
        nib = vec[4*(NDIG-1-i) +: 4];
      end
    end
    return nib;
  endfunction

  // A point is printed only when it actually splits the digit string.
  function automatic logic has_point(input logic [3:0] dp);
    return (dp != 4'd0) && (dp < NDIG_W);
  endfunction

  // Index of the integer-units digit: the last digit before the point, or
  // the final digit when there is no point.
  function automatic logic [3:0] units_of(input logic [3:0] dp);
    logic [3:0] res;
    if (has_point(dp)) begin
      res = LAST_IDX - dp;
    end else begin
      res = LAST_IDX;
    end
    return res;
  endfunction

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t            r_state;
  logic [4*NDIG-1:0] r_bcd;
  logic [3:0]        r_dp;
  logic [3:0]        r_idx;
  logic [7:0]        r_data;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;

  // -------------------------------------------------------------------------
  // Combinational helpers
  // -------------------------------------------------------------------------
  logic       w_xfer;
  logic       w_at_units;
  logic       w_at_last;
  logic [3:0] w_next_idx;
  logic [7:0] w_next_ascii;
  logic [3:0] w_first_idx;
  logic [7:0] w_first_ascii;

  assign w_xfer       = r_valid & tx_ready;
  assign w_at_units   = has_point(r_dp) && (r_idx == units_of(r_dp));
  assign w_at_last    = (r_idx == LAST_IDX);
  assign w_next_idx   = r_idx + 4'd1;
  assign w_next_ascii = to_ascii(digit_at(r_bcd, w_next_idx));

  // The first byte is presented on the same edge that captures the inputs,
  // so it is derived from the live bcd/dp_pos rather than the registers.
  assign w_first_ascii = to_ascii(digit_at(bcd, w_first_idx));

`ifdef LEADING_ZERO_BLANK_EN
  logic [NDIG-1:0] w_in_nz;
  logic [3:0]      w_in_units;

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_in_nz
      // Bit gi flags a non-'0' nibble at digit index gi (MS digit = 0).
      assign w_in_nz[gi] = |bcd[4*(NDIG-1-gi) +: 4];
    end
  endgenerate

  assign w_in_units = units_of(dp_pos);

  // First digit to send: earliest non-'0' digit, but never later than the
  // units digit so that a value of zero still prints one '0'.
  always_comb begin : p_first_idx
    logic found;
    found       = 1'b0;
    w_first_idx = w_in_units;
    for (int i = 0; i < NDIG; i++) begin
      if (!found && (w_in_nz[i] || (4'(i) == w_in_units))) begin
        w_first_idx = 4'(i);
        found       = 1'b1;
      end
    end
  end
`else
  assign w_first_idx = 4'd0;
`endif

  // -------------------------------------------------------------------------
  // Frame FSM. All outputs are registered; r_data/r_valid only change on
  // acceptance or on a transfer, which gives the hold-while-stalled
  // behaviour for free.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_bcd   <= '0;
      r_dp    <= 4'd0;
      r_idx   <= 4'd0;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_bcd   <= bcd;
            r_dp    <= dp_pos;
            r_idx   <= w_first_idx;
            r_data  <= w_first_ascii;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= DIGIT;
          end
        end

        DIGIT: begin
          if (w_xfer) begin
            if (w_at_units) begin
              r_data  <= ASCII_POINT;
              r_state <= POINT;
            end else if (w_at_last) begin
              r_data  <= ASCII_CR;
              r_state <= CR;
            end else begin
              r_idx   <= w_next_idx;
              r_data  <= w_next_ascii;
            end
          end
        end

        // A point always has at least one fractional digit after it.
        POINT: begin
          if (w_xfer) begin
            r_idx   <= w_next_idx;
            r_data  <= w_next_ascii;
            r_state <= DIGIT;
          end
        end

        CR: begin
          if (w_xfer) begin
            r_data  <= ASCII_LF;
            r_state <= LF;
          end
        end

        LF: begin
          if (w_xfer) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_idx   <= 4'd0;
            r_state <= IDLE;
          end
        end

        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign tx_data  = r_data;
  assign tx_valid = r_valid;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_bcd_ascii_sender.sv
// ---------------------------------------------------------------------------
// tb_bcd_ascii_sender
//
// Self-checking bench for bcd_ascii_sender (NDIG = 6). The expected byte
// stream of each frame is built by a small text-formatting model; the DUT
// stream is collected at the transfer points and compared against it.
// Honours LEADING_ZERO_BLANK_EN in the model when the macro is defined.
// ---------------------------------------------------------------------------
module tb_bcd_ascii_sender;

  localparam int NDIG = 6;

  logic        clk;
  logic        rst;
  logic        start;
  logic [23:0] bcd;
  logic [3:0]  dp_pos;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  int errors;
  int checks;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  bcd_ascii_sender #(.NDIG(NDIG)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bcd      (bcd),
    .dp_pos   (dp_pos),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Reference: format the number as text the way a person would print it.
  task automatic build_model(input logic [23:0] b, input logic [3:0] d);
    int  units;
    bit  pt;
    bit  lead;
    int  dig;
    exp_q.delete();
    pt    = (int'(d) != 0) && (int'(d) < NDIG);
    units = pt ? (NDIG - int'(d) - 1) : (NDIG - 1);
    lead  = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      dig = int'((b >> (4 * (NDIG - 1 - i))) & 24'hF);
`ifdef LEADING_ZERO_BLANK_EN
      if (lead && dig == 0 && i < units) continue;
`endif
      lead = 1'b0;
      exp_q.push_back(dig <= 9 ? 8'(48 + dig) : 8'h3F);
      if (pt && i == units) exp_q.push_back(8'h2E);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    start    = 1'b0;
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_frame(input logic [23:0] b, input logic [3:0] d);
    @(negedge clk);
    start  = 1'b1;
    bcd    = b;
    dp_pos = d;
  endtask

  // Follows one frame from the cycle after acceptance until done.
  // mode 0: tx_ready always high; 1: random tx_ready; 2: hold tx_ready low
  // for 3 cycles while the 2nd byte is presented. If chain is set, a new
  // start (nb/nd) is raised in the done cycle.
  task automatic collect(input string name, input logic [23:0] b,
                         input logic [3:0] d, input int mode, input bit chain,
                         input logic [23:0] nb, input logic [3:0] nd);
    bit         stalled;
    bit         finished;
    logic [7:0] hold_data;
    int         stall_cnt;
    int         done_cyc;
    bit         match;
    build_model(b, d);
    got_q.delete();
    stalled   = 1'b0;
    finished  = 1'b0;
    hold_data = 8'h00;
    stall_cnt = 0;
    done_cyc  = -1;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        checks++;
        if (busy !== 1'b1 || tx_valid !== 1'b1 || done !== 1'b0 || tx_data !== exp_q[0]) begin
          errors++;
          $display("FAIL %s first_byte: busy=%b valid=%b done=%b data=%h, required busy=1 valid=1 done=0 data=%h",
                   name, busy, tx_valid, done, tx_data, exp_q[0]);
        end
      end
      if (stalled) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== hold_data) begin
          errors++;
          $display("FAIL %s hold: valid=%b data=%h, required valid=1 data=%h",
                   name, tx_valid, tx_data, hold_data);
        end
      end
      if (done === 1'b1) begin
        finished = 1'b1;
        done_cyc = cyc;
        checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s end_state: busy=%b valid=%b, required 0 0", name, busy, tx_valid);
        end
        if (chain) begin
          start  = 1'b1;
          bcd    = nb;
          dp_pos = nd;
        end else begin
          start = 1'b0;
        end
        tx_ready = 1'b1;
      end else begin
        if (cyc > 0) begin
          checks++;
          if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_in_frame: busy=%b at cycle %0d, required 1", name, busy, cyc);
          end
        end
        // Noise on the request inputs must not disturb the frame.
        start  = 1'($urandom_range(0, 1));
        bcd    = 24'($urandom);
        dp_pos = 4'($urandom);
        case (mode)
          0:       tx_ready = 1'b1;
          1:       tx_ready = ($urandom_range(0, 3) != 0);
          default: begin
            if (got_q.size() == 1 && stall_cnt < 3) begin
              tx_ready = 1'b0;
              stall_cnt++;
            end else begin
              tx_ready = 1'b1;
            end
          end
        endcase
        stalled   = tx_valid && !tx_ready;
        hold_data = tx_data;
        if (tx_valid === 1'b1 && tx_ready) got_q.push_back(tx_data);
      end
    end
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL %s timeout: no done within 300 cycles", name);
      start = 1'b0;
    end
    match = (got_q.size() == exp_q.size());
    for (int i = 0; match && i < exp_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) match = 1'b0;
    end
    checks++;
    if (!match) begin
      errors++;
      $display("FAIL %s stream: got %p, required %p", name, got_q, exp_q);
    end else begin
      $display("frame %s bcd=%h dp=%0d bytes=%0d ok", name, b, d, got_q.size());
    end
    if (mode == 0) begin
      checks++;
      if (done_cyc != exp_q.size()) begin
        errors++;
        $display("FAIL %s timing: done at cycle %0d, required %0d", name, done_cyc, exp_q.size());
      end
    end
    if (mode == 2) begin
      checks++;
      if (stall_cnt != 3) begin
        errors++;
        $display("FAIL %s stall_count: %0d stalls applied, required 3", name, stall_cnt);
      end
    end
    if (!chain) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s done_pulse: done=%b busy=%b one cycle later, required 0 0", name, done, busy);
      end
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    start    = 1'b1;
    bcd      = 24'h987654;
    dp_pos   = 4'd2;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: valid=%b busy=%b done=%b data=%h, required 0 0 0 00",
               tx_valid, busy, done, tx_data);
    end
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: valid=%b busy=%b, required 0 0", tx_valid, busy);
    end
    $display("reset check done");
  endtask

  task automatic test_frames();
    do_reset();
    start_frame(24'h012345, 4'd0); collect("plain", 24'h012345, 4'd0, 0, 1'b0, 24'h0, 4'd0);
    start_frame(24'h000750, 4'd3); collect("point3", 24'h000750, 4'd3, 0, 1'b0, 24'h0, 4'd0);
    start_frame(24'h1A0000, 4'd0); collect("bad_nibble", 24'h1A0000, 4'd0, 0, 1'b0, 24'h0, 4'd0);
    start_frame(24'h123456, 4'd5); collect("point_max", 24'h123456, 4'd5, 0, 1'b0, 24'h0, 4'd0);
    start_frame(24'h003456, 4'd6); collect("dp_eq_ndig", 24'h003456, 4'd6, 0, 1'b0, 24'h0, 4'd0);
    start_frame(24'h000000, 4'd15); collect("zero_dp15", 24'h000000, 4'd15, 0, 1'b0, 24'h0, 4'd0);
    start_frame(24'h000000, 4'd1); collect("zero_dp1", 24'h000000, 4'd1, 0, 1'b0, 24'h0, 4'd0);
  endtask

  task automatic test_stall();
    do_reset();
    start_frame(24'h012345, 4'd0);
    collect("stall_2nd", 24'h012345, 4'd0, 2, 1'b0, 24'h0, 4'd0);
  endtask

  task automatic test_random();
    logic [23:0] b;
    logic [3:0]  d;
    do_reset();
    for (int n = 0; n < 12; n++) begin
      for (int k = 0; k < NDIG; k++) begin
        b[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      end
      d = 4'($urandom_range(0, 8));
      start_frame(b, d);
      collect($sformatf("rand%0d", n), b, d, 1, 1'b0, 24'h0, 4'd0);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    start_frame(24'h098700, 4'd2);
    collect("b2b_first", 24'h098700, 4'd2, 0, 1'b1, 24'h406001, 4'd4);
    collect("b2b_second", 24'h406001, 4'd4, 0, 1'b0, 24'h0, 4'd0);
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    build_model(24'h012345, 4'd0);
    start_frame(24'h012345, 4'd0);
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      start    = 1'b0;
      tx_ready = 1'b1;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_q[cyc]) begin
        errors++;
        $display("FAIL midreset_pre%0d: valid=%b data=%h, required 1 %h", cyc, tx_valid, tx_data, exp_q[cyc]);
      end
    end
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL midreset_abort: valid=%b busy=%b done=%b data=%h, required 0 0 0 00",
               tx_valid, busy, done, tx_data);
    end
    rst   = 1'b0;
    start = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midreset_quiet%0d: valid=%b done=%b busy=%b, required 0 0 0",
                 cyc, tx_valid, done, busy);
      end
    end
    $display("mid-frame reset check done");
  endtask

  initial begin
    clk      = 1'b0;
    rst      = 1'b1;
    start    = 1'b0;
    bcd      = 24'h0;
    dp_pos   = 4'd0;
    tx_ready = 1'b1;
    errors   = 0;
    checks   = 0;
    test_reset();
    test_frames();
    test_stall();
    test_random();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
